// File: rtl/axi_lite_write_arbiter_if.sv
// AXI-Lite write-channel bundle (AW, W, B) shared by the write arbiter and its slave.
interface AXI_LITE #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;

  modport Master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
    input  aw_ready, w_ready, b_resp, b_valid
  );

  modport Slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
    output aw_ready, w_ready, b_resp, b_valid
  );
endinterface

// File: rtl/axi_lite_write_arbiter.sv
// Arbitrates single-beat write requests from NUM_REQ requesters onto one AXI-Lite
// master port, one outstanding transaction at a time.
//
// state | meaning
// IDLE  | waiting for any req_i; grants and captures payload
// SEND  | AW and W valids held until each handshakes independently
// RESP  | b_ready high, waiting for the B response
module axi_lite_write_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  AXI_LITE.Master                                axi_master,
  input  logic [NUM_REQ-1:0]                     req_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     data_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]   strb_i,
  output logic [NUM_REQ-1:0]                     ack_o,
  output logic [NUM_REQ-1:0]                     done_o,
  output logic [NUM_REQ-1:0]                     err_o,
  output logic                                   busy_o
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [IDX_W-1:0]        pick, cand;
  logic                    any_req;
  logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0]   w_strb_q, w_strb_d;
  logic                    aw_valid_q, aw_valid_d;
  logic                    w_valid_q, w_valid_d;
  logic                    b_ready_q, b_ready_d;
  logic [NUM_REQ-1:0]      ack_d, done_d, err_d;
  logic                    busy_d;

  assign any_req = |req_i;

  // Round-robin walks last+NUM_REQ down to last+1 so the nearest candidate wins.
  always_comb begin
    pick = '0;
    cand = '0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_i[i]) pick = IDX_W'(i);
      end
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
        if (req_i[cand]) pick = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = 1'b0;
    ack_d      = '0;
    done_d     = '0;
    err_d      = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d     = pick;
          last_d      = pick;
          aw_addr_d   = addr_i[pick];
          w_data_d    = data_i[pick];
          w_strb_d    = strb_i[pick];
          aw_valid_d  = 1'b1;
          w_valid_d   = 1'b1;
          ack_d[pick] = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (aw_valid_q && axi_master.aw_ready) aw_valid_d = 1'b0;
        if (w_valid_q && axi_master.w_ready)   w_valid_d  = 1'b0;
        if (!aw_valid_d && !w_valid_d) begin
          state_d   = RESP;
          b_ready_d = 1'b1;
        end
      end
      RESP: begin
        if (axi_master.b_valid) begin
          done_d[grant_q] = 1'b1;
          err_d[grant_q]  = (axi_master.b_resp != 2'b00);
          state_d         = IDLE;
        end else begin
          b_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      ack_o      <= '0;
      done_o     <= '0;
      err_o      <= '0;
      busy_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      ack_o      <= ack_d;
      done_o     <= done_d;
      err_o      <= err_d;
      busy_o     <= busy_d;
    end
  end

  assign axi_master.aw_addr  = aw_addr_q;
  assign axi_master.aw_valid = aw_valid_q;
  assign axi_master.w_data   = w_data_q;
  assign axi_master.w_strb   = w_strb_q;
  assign axi_master.w_valid  = w_valid_q;
  assign axi_master.b_ready  = b_ready_q;
endmodule

// File: tb/tb_axi_lite_write_arbiter.sv
// Bench for axi_lite_write_arbiter: a fixed-priority and a round-robin instance
// (NUM_REQ=3, 64-bit data) checked against a transaction-level timing model.
module tb_axi_lite_write_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        req      [2];
  logic [2:0][31:0]  addr     [2];
  logic [2:0][63:0]  data     [2];
  logic [2:0][7:0]   strb     [2];
  logic              aw_ready [2];
  logic              w_ready  [2];
  logic              b_valid  [2];
  logic [1:0]        b_resp   [2];

  logic [31:0]       awa [2];
  logic              awv [2];
  logic [63:0]       wd  [2];
  logic [7:0]        ws  [2];
  logic              wv  [2];
  logic              br  [2];
  logic [2:0]        ack  [2];
  logic [2:0]        done [2];
  logic [2:0]        err  [2];
  logic              busy [2];

  for (genvar m = 0; m < 2; m++) begin : gen_dut
    AXI_LITE #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

    axi_lite_write_arbiter #(
      .NUM_REQ(3), .ADDR_WIDTH(32), .DATA_WIDTH(64), .ARB_MODE(m)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .axi_master(bus.Master),
      .req_i(req[m]), .addr_i(addr[m]), .data_i(data[m]), .strb_i(strb[m]),
      .ack_o(ack[m]), .done_o(done[m]), .err_o(err[m]), .busy_o(busy[m])
    );

    assign bus.aw_ready = aw_ready[m];
    assign bus.w_ready  = w_ready[m];
    assign bus.b_valid  = b_valid[m];
    assign bus.b_resp   = b_resp[m];
    assign awa[m] = bus.aw_addr;
    assign awv[m] = bus.aw_valid;
    assign wd[m]  = bus.w_data;
    assign ws[m]  = bus.w_strb;
    assign wv[m]  = bus.w_valid;
    assign br[m]  = bus.b_ready;
  end

  int total = 0;
  int bad   = 0;
  int last_m [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant rule: instance 0 lowest index wins; instance 1 searches from last+1.
  function automatic int model_pick(input int m, input logic [2:0] mask);
    int g;
    g = -1;
    if (m == 0) begin
      for (int i = 2; i >= 0; i--) if (mask[i]) g = i;
    end else begin
      for (int k = 3; k >= 1; k--) if (mask[(last_m[m] + k) % 3]) g = (last_m[m] + k) % 3;
    end
    return g;
  endfunction

  task automatic randomize_payload(input int m);
    for (int i = 0; i < 3; i++) begin
      addr[m][i] = $urandom;
      data[m][i] = {$urandom, $urandom};
      strb[m][i] = 8'($urandom);
    end
  endtask

  // One write from the IDLE sample cycle (cycle 0) to the done_o cycle.
  // AW handshakes in cycle 1+awd, W in 1+wd; RESP starts at 2+max; b_valid after bd RESP cycles.
  task automatic do_txn(input int m, input logic [2:0] mask, input int awd, input int wdl,
                        input int bd, input logic [1:0] resp, input bit scramble);
    int g, r, fin;
    logic [31:0] ea;
    logic [63:0] ed;
    logic [7:0]  es;
    req[m]      = mask;
    aw_ready[m] = (awd == 0);
    w_ready[m]  = (wdl == 0);
    b_valid[m]  = 1'b0;
    g = model_pick(m, mask);
    if (g < 0) begin
      tick();
      check("idle_ack", 64'(ack[m]), 64'(0));
      check("idle_busy", 64'(busy[m]), 64'(0));
      check("idle_awv", 64'(awv[m]), 64'(0));
      return;
    end
    last_m[m] = g;
    ea = addr[m][g];
    ed = data[m][g];
    es = strb[m][g];
    r   = 2 + ((awd > wdl) ? awd : wdl);
    fin = r + bd + 1;
    for (int c = 1; c <= fin; c++) begin
      tick();
      check("ack", 64'(ack[m]), (c == 1) ? 64'(3'b001 << g) : 64'(0));
      check("busy", 64'(busy[m]), 64'(c < fin));
      check("aw_valid", 64'(awv[m]), 64'(c <= 1 + awd));
      check("w_valid", 64'(wv[m]), 64'(c <= 1 + wdl));
      check("b_ready", 64'(br[m]), 64'(c >= r && c < fin));
      check("done", 64'(done[m]), (c == fin) ? 64'(3'b001 << g) : 64'(0));
      check("err", 64'(err[m]), (c == fin && resp != 2'b00) ? 64'(3'b001 << g) : 64'(0));
      if (c <= 1 + awd) check("aw_addr", 64'(awa[m]), 64'(ea));
      if (c <= 1 + wdl) begin
        check("w_data", wd[m], ed);
        check("w_strb", 64'(ws[m]), 64'(es));
      end
      aw_ready[m] = (c == 1 + awd) ? 1'b1 : (c < 1 + awd) ? 1'b0 : 1'($urandom);
      w_ready[m]  = (c == 1 + wdl) ? 1'b1 : (c < 1 + wdl) ? 1'b0 : 1'($urandom);
      b_valid[m]  = (c == fin - 1);
      b_resp[m]   = (c == fin - 1) ? resp : 2'($urandom);
      if (scramble) begin
        req[m] = 3'($urandom);
        randomize_payload(m);
      end
      if (c == fin) req[m] = 3'b000;
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      req[m] = '0; aw_ready[m] = 1'b0; w_ready[m] = 1'b0;
      b_valid[m] = 1'b0; b_resp[m] = 2'b00;
      randomize_payload(m);
      last_m[m] = 2;
    end
    tick();
    tick();
    for (int m = 0; m < 2; m++) begin
      check("rst_aw_addr", 64'(awa[m]), 64'(0));
      check("rst_w_data", wd[m], 64'(0));
      check("rst_w_strb", 64'(ws[m]), 64'(0));
      check("rst_aw_valid", 64'(awv[m]), 64'(0));
      check("rst_w_valid", 64'(wv[m]), 64'(0));
      check("rst_b_ready", 64'(br[m]), 64'(0));
      check("rst_ack", 64'(ack[m]), 64'(0));
      check("rst_done", 64'(done[m]), 64'(0));
      check("rst_err", 64'(err[m]), 64'(0));
      check("rst_busy", 64'(busy[m]), 64'(0));
    end
    rst_n = 1'b1;
    tick();

    // fixed priority: 110 grants 1, then 111 grants 0
    randomize_payload(0);
    do_txn(0, 3'b110, 0, 0, 0, 2'b00, 1'b0);
    randomize_payload(0);
    do_txn(0, 3'b111, 0, 0, 0, 2'b00, 1'b0);

    // round-robin with all requests held: 0,1,2,0,1,2 back to back
    for (int n = 0; n < 6; n++) begin
      randomize_payload(1);
      do_txn(1, 3'b111, 0, 0, 0, 2'b00, 1'b0);
    end

    // AW stalled four cycles, W immediate
    randomize_payload(1);
    do_txn(1, 3'b011, 4, 0, 0, 2'b00, 1'b0);
    randomize_payload(1);
    do_txn(1, 3'b100, 0, 3, 2, 2'b00, 1'b0);

    // SLVERR on requester 1, then OKAY on requester 0; DECERR also flags
    randomize_payload(1);
    do_txn(1, 3'b010, 0, 0, 1, 2'b10, 1'b0);
    randomize_payload(1);
    do_txn(1, 3'b001, 0, 0, 0, 2'b00, 1'b0);
    randomize_payload(0);
    do_txn(0, 3'b100, 1, 1, 0, 2'b11, 1'b0);

    // 64-bit payload with partial strobe
    randomize_payload(1);
    addr[1][2] = 32'h4000_0010;
    data[1][2] = 64'hDEAD_BEEF_CAFE_F00D;
    strb[1][2] = 8'h0F;
    do_txn(1, 3'b100, 0, 0, 0, 2'b00, 1'b0);

    // randomized traffic with requests/payloads churning after grant
    for (int n = 0; n < 40; n++) begin
      for (int m = 0; m < 2; m++) begin
        randomize_payload(m);
        do_txn(m, 3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), 2'($urandom), 1'b1);
      end
    end

    // asynchronous reset while stalled in SEND
    req[1] = 3'b111; aw_ready[1] = 1'b0; w_ready[1] = 1'b0;
    randomize_payload(1);
    tick();
    check("pre_rst_aw_valid", 64'(awv[1]), 64'(1));
    check("pre_rst_busy", 64'(busy[1]), 64'(1));
    tick();
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_aw_valid", 64'(awv[1]), 64'(0));
    check("async_rst_w_valid", 64'(wv[1]), 64'(0));
    check("async_rst_busy", 64'(busy[1]), 64'(0));
    check("async_rst_aw_addr", 64'(awa[1]), 64'(0));
    last_m[0] = 2;
    last_m[1] = 2;
    tick();
    rst_n = 1'b1;
    randomize_payload(1);
    do_txn(1, 3'b111, 0, 0, 0, 2'b00, 1'b0);
    randomize_payload(1);
    do_txn(1, 3'b111, 1, 0, 0, 2'b00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
